// File: rtl/fir_decim_out_if.sv
// Valid/ready output bus carrying rescaled, decimated samples from fir_decim_out.
interface fir_decim_out_if #(
    parameter int DOUT_W = 16
) ();
    logic              m_valid;
    logic              m_ready;
    logic [DOUT_W-1:0] m_data;

    modport master (output m_valid, output m_data, input m_ready);
    modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/fir_decim_out.sv
// FIR output stage: decimate by DECIM, round/shift/saturate each kept sample,
// and queue results in a show-ahead FIFO with sticky overflow/saturation flags.
module fir_decim_out #(
    parameter int DIN_W  = 32,
    parameter int DOUT_W = 16,
    parameter int DECIM  = 4,
    parameter int SHIFT  = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DIN_W-1:0]           y_in,
    input  logic                       en,
    input  logic                       phase_clr,
    input  logic                       flag_clr,
    fir_decim_out_if.master            m,
    output logic [$clog2(DEPTH):0]     fill,
    output logic                       overflow,
    output logic                       sat
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

    localparam logic [PW-1:0]          PH_LAST  = PW'(DECIM - 1);
    localparam logic [PW-1:0]          PH_ALIGN = (DECIM > 1) ? PW'(1) : '0;
    localparam logic [AW:0]            FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [DOUT_W-1:0]      MAX_OUT  = {1'b0, {(DOUT_W-1){1'b1}}};
    localparam logic [DOUT_W-1:0]      MIN_OUT  = {1'b1, {(DOUT_W-1){1'b0}}};
    localparam logic signed [DIN_W:0]  HALF     = (DIN_W + 1)'(1) << (SHIFT - 1);
    localparam logic signed [DIN_W:0]  MAXV     = {{(DIN_W+1-DOUT_W){1'b0}}, MAX_OUT};
    localparam logic signed [DIN_W:0]  MINV     = {{(DIN_W+1-DOUT_W){1'b1}}, MIN_OUT};

    // ---------------- decimation phase ----------------
    logic [PW-1:0] ph_reg;
    logic          keep;

    assign keep = en && ((ph_reg == '0) || phase_clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_reg <= '0;
        end else if (phase_clr) begin
            ph_reg <= PH_ALIGN;
        end else if (en) begin
            ph_reg <= (ph_reg == PH_LAST) ? '0 : ph_reg + PW'(1);
        end
    end

    // ---------------- round, shift, saturate ----------------
    logic signed [DIN_W:0] sum_ext;
    logic signed [DIN_W:0] shifted;
    logic [DOUT_W-1:0]     scaled;
    logic                  sat_now;

    always_comb begin
        // One extra bit keeps the rounding add from wrapping near full scale.
        sum_ext = $signed({y_in[DIN_W-1], y_in}) + HALF;
        shifted = sum_ext >>> SHIFT;
        sat_now = 1'b0;
        scaled  = shifted[DOUT_W-1:0];
        if (shifted > MAXV) begin
            scaled  = MAX_OUT;
            sat_now = 1'b1;
        end else if (shifted < MINV) begin
            scaled  = MIN_OUT;
            sat_now = 1'b1;
        end
    end

    // ---------------- stage 1 ----------------
    logic              s1_kept_reg;
    logic [DOUT_W-1:0] s1_data_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_kept_reg <= 1'b0;
            s1_data_reg <= '0;
        end else begin
            s1_kept_reg <= keep;
            if (keep) begin
                s1_data_reg <= scaled;
            end
        end
    end

    // ---------------- FIFO ----------------
    logic [DOUT_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [AW-1:0]     rd_ptr_inc;
    logic [AW:0]       fill_reg;
    logic [AW:0]       fill_next;
    logic              valid_reg;
    logic [DOUT_W-1:0] data_reg;
    logic [DOUT_W-1:0] head_next;
    logic              full;
    logic              pop;
    logic              push_ok;
    logic              drop;

    assign full       = (fill_reg == FULL_CNT);
    assign pop        = valid_reg && m.m_ready;
    assign push_ok    = s1_kept_reg && (!full || pop);
    assign drop       = s1_kept_reg && full && !pop;
    assign rd_ptr_inc = rd_ptr_reg + AW'(1);

    always_comb begin
        fill_next = fill_reg;
        case ({push_ok, pop})
            2'b10:   fill_next = fill_reg + (AW + 1)'(1);
            2'b01:   fill_next = fill_reg - (AW + 1)'(1);
            default: fill_next = fill_reg;
        endcase
    end

    // The head is kept in its own register so m_data is a clean flop output;
    // it is fed either from the entry behind the head or straight from stage 1.
    always_comb begin
        head_next = data_reg;
        if (pop) begin
            if (fill_reg > (AW + 1)'(1)) begin
                head_next = mem[rd_ptr_inc];
            end else if (push_ok) begin
                head_next = s1_data_reg;
            end
        end else if ((fill_reg == '0) && push_ok) begin
            head_next = s1_data_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= s1_data_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            fill_reg   <= '0;
            valid_reg  <= 1'b0;
            data_reg   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_inc;
            end
            fill_reg  <= fill_next;
            valid_reg <= (fill_next != '0);
            data_reg  <= head_next;
        end
    end

    // ---------------- sticky flags (set beats clear) ----------------
    logic overflow_reg;
    logic sat_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_reg <= 1'b0;
            sat_reg      <= 1'b0;
        end else begin
            overflow_reg <= drop | (overflow_reg & ~flag_clr);
            sat_reg      <= (keep & sat_now) | (sat_reg & ~flag_clr);
        end
    end

    assign m.m_valid = valid_reg;
    assign m.m_data  = data_reg;
    assign fill      = fill_reg;
    assign overflow  = overflow_reg;
    assign sat       = sat_reg;
endmodule

// File: doc/fir_decim_out.md
# fir_decim_out

Output stage on the far side of the FIR filter: it consumes the filter's full-rate 32-bit output stream (one sample per clock), keeps one sample in every DECIM, and rescales each kept sample with rounding and saturation. Results are delivered through a small show-ahead FIFO to a valid/ready consumer. Overflow and saturation events are reported on sticky status flags.

## Interface
- DIN_W, 32, input sample width (signed two's complement, matches FIR y)
- DOUT_W, 16, output sample width (signed)
- DECIM, 4, decimation factor (>=1)
- SHIFT, 8, arithmetic right-shift applied to kept samples (>=1)
- DEPTH, 4, FIFO entries (power of 2, >=2)
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- y_in  in  DIN_W  FIR output sample
- en  in  1  y_in valid this cycle (tied high when FIR runs every clock)
- phase_clr  in  1  realign decimation phase
- flag_clr  in  1  clear sticky flags
- m_valid  out  1  FIFO head valid
- m_ready  in  1  consumer accepts head
- m_data  out  DOUT_W  FIFO head sample
- fill  out  log2(DEPTH)+1  FIFO occupancy
- overflow  out  1  sticky: kept sample dropped because FIFO full
- sat  out  1  sticky: kept sample saturated

## Operation
- Phase counter ph in 0..DECIM-1, advances by 1 (wrapping) on each cycle with en=1; holds when en=0.
- Sample kept when en=1 and (ph==0 or phase_clr=1). phase_clr=1 sets ph to 1 mod DECIM, independent of en (0 if DECIM=1). DECIM=1 keeps every en sample.
- Scaling, DIN_W+1-bit signed arithmetic: r = (y_in + 2^(SHIFT-1)) >>> SHIFT (round half toward +inf).
- Saturation: r > 2^(DOUT_W-1)-1 gives 2^(DOUT_W-1)-1; r < -2^(DOUT_W-1) gives -2^(DOUT_W-1); either case sets sat.
- Stage 1 register holds the scaled value plus a kept bit. Stage 2 pushes it into the FIFO.
- Pop when m_valid && m_ready. Push while full succeeds only if a pop happens the same edge; otherwise the sample is dropped, FIFO is unchanged and overflow is set.
- Push and pop on the same edge, not full: fill unchanged. Empty FIFO with a push: no pop that edge; the head becomes valid after it.
- FIFO order is strict FIFO; pointers wrap modulo DEPTH; fill is 0..DEPTH.
- flag_clr=1 clears overflow and sat at the next edge. A set event on that same edge wins (flag ends 1).
- m_data shows the head entry when m_valid=1. It holds its last value when empty.

## Timing
- Reset (async assert, state updates resume on first edge after deassert): ph=0, stage 1 empty, FIFO empty, m_valid=0, m_data=0, fill=0, overflow=0, sat=0.
- Latency: sample presented before edge k is in stage 1 after k, in FIFO after k+1. With an empty FIFO, m_valid=1 in the cycle after edge k+1.
- fill and m_valid are registered and update on the same edge as the push/pop.
- Throughput: one push and one pop per clock sustained.
- rst_n asserted mid-stream discards stage 1 and FIFO contents immediately. There is no partial output.
- m_valid never deasserts without a pop or reset. m_data is stable while m_valid=1 and m_ready=0.

## Test plan
- Ramp: after reset, en=1, m_ready=1, y_in=256*n (n=0,1,2,...), defaults. Required: m_data = 0,4,8,12,... First m_valid occurs the cycle after the second edge; a new valid every 4 cycles; flags stay 0.
- Rounding: kept y_in=384 gives m_data=2. Kept y_in=-384 (0xFFFFFE80) gives m_data=-1 (0xFFFF). Kept y_in=127 gives 0; kept 128 gives 1.
- Saturation: kept y_in=0x7FFFFFFF gives m_data=0x7FFF and sat=1. Kept 0x80000000 gives 0x8000. flag_clr pulse gives sat=0 the next cycle.
- Backpressure/overflow: m_ready=0, 5 kept samples. Required: fill reaches 4, the 5th is dropped, overflow=1. Then m_ready=1 drains exactly the first 4 in order, then m_valid=0 and fill=0.
- Full with simultaneous pop: fill=4, m_ready=1 on the edge a kept sample arrives. Required: sample accepted, fill stays 4, overflow stays 0.
- Phase realign and reset: phase_clr pulsed with en=1 at ph=2. That sample is kept; the next kept sample is 4 en-cycles later. Then rst_n pulsed low with fill=3. Required: m_valid=0, fill=0 and flags 0 immediately; after release the ramp restarts cleanly.
